// File: rtl/axis_sample_sequencer_if.sv
// Signal bundle between the sample sequencer, the byte-level SPI master
// and the axis data router.
interface axis_sample_sequencer_if;
  logic        spi_cs_n;
  logic        spi_tx_valid;
  logic [7:0]  spi_tx_byte;
  logic        spi_ready;
  logic        spi_rx_valid;
  logic [7:0]  spi_rx_byte;
  logic        o_Load;
  logic [15:0] o_Data;
  logic [1:0]  o_Byte_Count;

  modport master (
    output spi_cs_n, spi_tx_valid, spi_tx_byte, o_Load, o_Data, o_Byte_Count,
    input  spi_ready, spi_rx_valid, spi_rx_byte
  );

  modport slave (
    input  spi_cs_n, spi_tx_valid, spi_tx_byte, o_Load, o_Data, o_Byte_Count,
    output spi_ready, spi_rx_valid, spi_rx_byte
  );
endinterface

// File: rtl/axis_sample_sequencer.sv
// Periodic accelerometer X/Y/Z burst reader: SPI byte sequencing, 16-bit
// word assembly, router load strobes and the one-hot axis display select.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | chip select high, waiting for a sample tick with enable
// CS_SETUP  | chip select low for one cycle before the first byte
// SEND_CMD  | offer/transfer the read command, then wait for its rx
// SEND_ADDR | offer/transfer the first register address, wait for rx
// READ      | offer/transfer dummy bytes, capture low/high data bytes
// LOAD      | one-cycle router load strobe for the assembled word
// CS_HOLD   | last cycle with chip select low after the Z load
module axis_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter logic [7:0]  CMD_READ   = 8'h0B,
  parameter logic [7:0]  REG_BASE   = 8'h0E
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          axis_btn,
  axis_sample_sequencer_if.master       bus,
  output logic                          show_X,
  output logic                          show_Y,
  output logic                          show_Z,
  output logic                          o_frame_done,
  output logic                          o_overrun
);

  localparam int unsigned      DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SEND_CMD, SEND_ADDR, READ, LOAD, CS_HOLD
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             xfer;
  logic             rx_done;
  logic             wait_rx;
  logic [2:0]       rx_idx;
  logic [7:0]       low_byte;
  logic [15:0]      data_q;
  logic [1:0]       slot_q;
  logic             done_q;
  logic             ovr_q;
  logic [2:0]       show_q;

  assign tick    = (div_cnt == DIV_LAST);
  assign xfer    = bus.spi_tx_valid && bus.spi_ready;
  assign rx_done = wait_rx && bus.spi_rx_valid;

  // Free-running sample divider, independent of enable and of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the first IDLE cycle after a frame (done_q) refuses a
  // tick so chip select stays high for at least one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (tick && enable && !done_q) state_nxt = CS_SETUP;
      CS_SETUP:  state_nxt = SEND_CMD;
      SEND_CMD:  if (rx_done) state_nxt = SEND_ADDR;
      SEND_ADDR: if (rx_done) state_nxt = READ;
      READ:      if (rx_done && rx_idx[0]) state_nxt = LOAD;
      LOAD:      state_nxt = (rx_idx == 3'd6) ? CS_HOLD : READ;
      CS_HOLD:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; tx_valid is withheld while a byte is in flight.
  always_comb begin
    bus.spi_cs_n     = (state == IDLE);
    bus.spi_tx_valid = 1'b0;
    bus.spi_tx_byte  = 8'h00;
    case (state)
      SEND_CMD: begin
        bus.spi_tx_valid = !wait_rx;
        bus.spi_tx_byte  = CMD_READ;
      end
      SEND_ADDR: begin
        bus.spi_tx_valid = !wait_rx;
        bus.spi_tx_byte  = REG_BASE;
      end
      READ: begin
        bus.spi_tx_valid = !wait_rx;
        bus.spi_tx_byte  = 8'h00;
      end
      default: ;
    endcase
    bus.o_Load       = (state == LOAD);
    bus.o_Data       = data_q;
    bus.o_Byte_Count = slot_q;
    o_frame_done     = done_q;
    o_overrun        = ovr_q;
    {show_Z, show_Y, show_X} = show_q;
  end

  // Byte tracking, word assembly and the done/overrun pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_rx  <= 1'b0;
      rx_idx   <= 3'd0;
      low_byte <= 8'h00;
      data_q   <= 16'h0000;
      slot_q   <= 2'd0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      done_q <= (state == CS_HOLD);
      ovr_q  <= tick && enable && ((state != IDLE) || done_q);
      if (xfer)         wait_rx <= 1'b1;
      else if (rx_done) wait_rx <= 1'b0;
      if (state == IDLE) begin
        rx_idx <= 3'd0;
      end else if ((state == READ) && rx_done) begin
        rx_idx <= rx_idx + 3'd1;
        if (rx_idx[0]) begin
          data_q <= {bus.spi_rx_byte, low_byte};
          slot_q <= 2'd2 - rx_idx[2:1];
        end else begin
          low_byte <= bus.spi_rx_byte;
        end
      end
    end
  end

  // One-hot display select rotating X -> Y -> Z -> X on each button pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           show_q <= 3'b001;
    else if (axis_btn) show_q <= {show_q[1:0], show_q[2]};
  end

endmodule
